// File: rtl/pipe_subtractor_16bit.sv
// pipe_subtractor_16bit
//
// Two-stage pipelined subtractor. It computes diff = a - b - bin modulo 2^WIDTH,
// plus the unsigned borrow-out and the signed overflow flag. The low half is
// subtracted in stage 1 and the high half in stage 2. A valid/ready handshake is
// used on both sides, and the block can hold up to two results under
// backpressure.
//
// Parameters
//   WIDTH      operand width; must be even (split into two halves of WIDTH/2)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operand set present on a, b, bin
//   in_ready   block accepts operands this cycle (combinational)
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  result present on diff, bout, ovf
//   out_ready  consumer accepts the result this cycle
//   diff       a - b - bin modulo 2^WIDTH
//   bout       1 iff unsigned a < b + bin
//   ovf        signed overflow of the subtraction
module pipe_subtractor_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int H = WIDTH / 2;

  // stage 1 registers
  logic         v1;
  logic [H-1:0] lo_diff;
  logic         lo_borrow;
  logic [H-1:0] a_hi;
  logic [H-1:0] b_hi;

  // stage 2 valid (data lives directly in the output registers)
  logic         v2;

  logic         stage2_load;
  logic         accept;
  logic [H:0]   lo_full;
  logic [H:0]   hi_full;
  logic         ovf_next;

  // Stage 2 takes stage 1's result when it is empty or being drained this cycle.
  // Stage 1 can take new operands when it is empty or is being moved on.
  always_comb begin
    stage2_load = v1 & (~v2 | out_ready);
    in_ready    = ~v1 | stage2_load;
    accept      = in_valid & in_ready;
  end

  // The extra top bit of each (H+1)-bit subtraction is the borrow out of that half.
  always_comb begin
    lo_full  = {1'b0, a[H-1:0]} - {1'b0, b[H-1:0]} - {{H{1'b0}}, bin};
    hi_full  = {1'b0, a_hi} - {1'b0, b_hi} - {{H{1'b0}}, lo_borrow};
    ovf_next = (a_hi[H-1] != b_hi[H-1]) && (hi_full[H-1] != a_hi[H-1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      lo_diff   <= '0;
      lo_borrow <= 1'b0;
      a_hi      <= '0;
      b_hi      <= '0;
    end else begin
      if (accept) begin
        v1        <= 1'b1;
        lo_diff   <= lo_full[H-1:0];
        lo_borrow <= lo_full[H];
        a_hi      <= a[WIDTH-1:H];
        b_hi      <= b[WIDTH-1:H];
      end else if (stage2_load) begin
        v1 <= 1'b0;
      end
    end
  end

  // Output registers keep their last loaded value whenever nothing new arrives,
  // so a stalled or already-consumed result stays visible on diff/bout/ovf.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (stage2_load) begin
        v2   <= 1'b1;
        diff <= {hi_full[H-1:0], lo_diff};
        bout <= hi_full[H];
        ovf  <= ovf_next;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_pipe_subtractor_16bit.sv
// tb_pipe_subtractor_16bit
//
// Self-checking bench for pipe_subtractor_16bit. It covers:
//   - a table of directed single-transaction vectors with hand-computed results,
//   - reset behaviour,
//   - backpressure with four streamed operand sets,
//   - a reset applied while results are in flight.
// Inputs are driven on the falling edge, and outputs are sampled on the falling
// edge as well.
module tb_pipe_subtractor_16bit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  pipe_subtractor_16bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one value and reports any difference.
  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Sends one vector with out_ready held high. It checks the 2-edge latency,
  // the single-cycle out_valid pulse, and that the result is held afterwards.
  task automatic apply_stimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    a         = v.a;
    b         = v.b;
    bin       = v.bin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_output($sformatf("vec%0d in_ready", idx), {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_output($sformatf("vec%0d early out_valid", idx), {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    check_output($sformatf("vec%0d out_valid", idx), {15'd0, out_valid}, 16'd1);
    check_output($sformatf("vec%0d diff", idx), diff, v.exp_diff);
    check_output($sformatf("vec%0d bout", idx), {15'd0, bout}, {15'd0, v.exp_bout});
    check_output($sformatf("vec%0d ovf", idx), {15'd0, ovf}, {15'd0, v.exp_ovf});
    @(negedge clk);
    check_output($sformatf("vec%0d out_valid drop", idx), {15'd0, out_valid}, 16'd0);
    check_output($sformatf("vec%0d diff retained", idx), diff, v.exp_diff);
  endtask

  initial begin
    int idx;
    int next_out;
    int cycles;
    logic took;

    tests_run    = 0;
    tests_failed = 0;

    // Directed vectors: a, b, bin, expected diff, bout, ovf
    vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[5]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[6]  = '{16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
    vecs[10] = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[11] = '{16'h00FF, 16'h0100, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[12] = '{16'h0200, 16'h0101, 1'b1, 16'h00FE, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    // Reset asserted between edges must clear the outputs without waiting for a clock edge
    #2 reset = 1'b0;
    #1;
    check_output("reset out_valid", {15'd0, out_valid}, 16'd0);
    check_output("reset diff", diff, 16'h0000);
    check_output("reset bout", {15'd0, bout}, 16'd0);
    check_output("reset ovf", {15'd0, ovf}, 16'd0);
    check_output("reset in_ready", {15'd0, in_ready}, 16'd1);

    // Operands presented during reset must not be taken
    a        = 16'h1234;
    b        = 16'h0001;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("in-reset out_valid", {15'd0, out_valid}, 16'd0);
    check_output("in-reset in_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b0;
    reset    = 1'b1;

    // The vector table starts with the first edge after release
    for (int i = 0; i < NVEC; i++) apply_stimulus(i);

    // Backpressure: stream four sets with out_ready low; only two may be taken
    @(negedge clk);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      a        = vecs[idx].a;
      b        = vecs[idx].b;
      bin      = vecs[idx].bin;
      in_valid = 1'b1;
      #1;
      took = in_ready;
      @(posedge clk);
      if (took) idx++;
      @(negedge clk);
    end
    check_output("bp accepted count", 16'(idx), 16'd2);
    check_output("bp in_ready", {15'd0, in_ready}, 16'd0);
    check_output("bp out_valid", {15'd0, out_valid}, 16'd1);
    check_output("bp hold diff", diff, vecs[0].exp_diff);
    @(negedge clk);
    check_output("bp hold diff 2", diff, vecs[0].exp_diff);
    check_output("bp hold bout", {15'd0, bout}, {15'd0, vecs[0].exp_bout});

    // Release the stall; all four results must come out back-to-back, in order
    out_ready = 1'b1;
    next_out  = 0;
    cycles    = 0;
    while (next_out < 4 && cycles < 20) begin
      check_output($sformatf("drain%0d out_valid", next_out), {15'd0, out_valid}, 16'd1);
      if (out_valid) begin
        check_output($sformatf("drain%0d diff", next_out), diff, vecs[next_out].exp_diff);
        check_output($sformatf("drain%0d bout", next_out), {15'd0, bout},
                     {15'd0, vecs[next_out].exp_bout});
        check_output($sformatf("drain%0d ovf", next_out), {15'd0, ovf},
                     {15'd0, vecs[next_out].exp_ovf});
        next_out++;
      end
      if (idx < 4) begin
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        bin      = vecs[idx].bin;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      took = in_valid & in_ready;
      @(posedge clk);
      if (took) idx++;
      @(negedge clk);
      cycles++;
    end
    check_output("drain complete", 16'(next_out), 16'd4);
    check_output("drain empty", {15'd0, out_valid}, 16'd0);

    // Mid-operation reset with two results in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      a        = vecs[4 + c].a;
      b        = vecs[4 + c].b;
      bin      = vecs[4 + c].bin;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_output("inflight out_valid", {15'd0, out_valid}, 16'd1);
    check_output("inflight in_ready", {15'd0, in_ready}, 16'd0);
    #2 reset = 1'b0;
    #1;
    check_output("midreset out_valid", {15'd0, out_valid}, 16'd0);
    check_output("midreset in_ready", {15'd0, in_ready}, 16'd1);
    check_output("midreset diff", diff, 16'h0000);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("post-reset idle%0d", c), {15'd0, out_valid}, 16'd0);
    end
    apply_stimulus(12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net in case the stimulus ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
